riscv_wb_arbiter: RTL and testbench

RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/riscv_wb_fifo.sv | 67 ++++++
 rtl/riscv_wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_riscv_wb_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the register-file writeback path: register index, XLEN word,
// and the buffered writeback entry, plus a saturating increment helper.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef logic [4:0]      reg_idx_t;
  typedef logic [XLEN-1:0] xlen_t;

  typedef struct packed {
    reg_idx_t rd;
    xlen_t    data;
  } wb_entry_t;

  function automatic xlen_t sat_inc(input xlen_t v);
    return (v == '1) ? v : v + xlen_t'(1);
  endfunction

endpackage

// File: rtl/riscv_wb_fifo.sv
// In-order ALU writeback buffer; exposes every slot so the issue stage can
// check read-after-write hazards against results not yet written back.
module riscv_wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   push_in,
  input  wb_entry_t              push_entry_in,
  input  logic                   pop_in,
  output logic                   full_out,
  output logic                   empty_out,
  output wb_entry_t              head_out,
  output logic      [DEPTH-1:0]  entry_valid_out,
  output wb_entry_t [DEPTH-1:0]  entries_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic      [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic      [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic      [DEPTH-1:0] valid_q,  valid_d;
  wb_entry_t [DEPTH-1:0] mem_q,    mem_d;

  // Valid bits form a contiguous ring, so slot occupancy alone gives full/empty.
  assign full_out        = valid_q[wr_ptr_q];
  assign empty_out       = !valid_q[rd_ptr_q];
  assign head_out        = mem_q[rd_ptr_q];
  assign entry_valid_out = valid_q;
  assign entries_out     = mem_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    mem_d    = mem_q;
    if (pop_in && !empty_out) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + AW'(1);
    end
    // Pop is applied first so a push into a full buffer that drains this cycle reuses the freed slot.
    if (push_in && (!full_out || (pop_in && !empty_out))) begin
      mem_d[wr_ptr_q]   = push_entry_in;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Register-file write port arbiter: loads win over buffered ALU results, with a
// pending-load scoreboard driving issue stall. Perf counters need WB_ARB_PERF_EN.
module riscv_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int ALU_FIFO_DEPTH = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        alu_valid_in,
  input  logic [4:0]  alu_rd_in,
  input  logic [31:0] alu_data_in,
  output logic        alu_ready_out,
  input  logic        mem_valid_in,
  input  logic [4:0]  mem_rd_in,
  input  logic [31:0] mem_data_in,
  input  logic        issue_valid_in,
  input  logic        issue_is_load_in,
  input  logic [4:0]  issue_ra_in,
  input  logic [4:0]  issue_rb_in,
  input  logic [4:0]  issue_rd_in,
  output logic        stall_out,
  output logic        write_enable_out,
  output logic [4:0]  rd_out,
  output logic [31:0] wd_out,
  output logic [31:0] stall_cycles_out,
  output logic [31:0] conflict_cycles_out
);

  logic                           fifo_full, fifo_empty, fifo_push, fifo_pop;
  wb_entry_t                      fifo_head, alu_entry;
  logic      [ALU_FIFO_DEPTH-1:0] fifo_vld;
  wb_entry_t [ALU_FIFO_DEPTH-1:0] fifo_entries;

  logic              mem_win, fifo_hit;
  logic              we_q, we_d;
  reg_idx_t          rd_q, rd_d;
  xlen_t             wd_q, wd_d;
  logic [NREGS-1:0]  pending_q, pending_d;

  // Gating everything on rst_n_in keeps inputs from having any effect while in reset.
  assign mem_win       = rst_n_in && mem_valid_in && (mem_rd_in != '0);
  assign fifo_pop      = rst_n_in && !mem_win && !fifo_empty;
  assign alu_ready_out = rst_n_in && (!fifo_full || fifo_pop);
  assign fifo_push     = alu_valid_in && alu_ready_out && (alu_rd_in != '0);
  assign alu_entry     = '{rd: alu_rd_in, data: alu_data_in};

  riscv_wb_fifo #(
    .DEPTH(ALU_FIFO_DEPTH)
  ) u_fifo (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .push_in         (fifo_push),
    .push_entry_in   (alu_entry),
    .pop_in          (fifo_pop),
    .full_out        (fifo_full),
    .empty_out       (fifo_empty),
    .head_out        (fifo_head),
    .entry_valid_out (fifo_vld),
    .entries_out     (fifo_entries)
  );

  always_comb begin
    fifo_hit = 1'b0;
    for (int i = 0; i < ALU_FIFO_DEPTH; i++) begin
      if (fifo_vld[i] &&
          (((issue_ra_in != '0) && (fifo_entries[i].rd == issue_ra_in)) ||
           ((issue_rb_in != '0) && (fifo_entries[i].rd == issue_rb_in))))
        fifo_hit = 1'b1;
    end
    stall_out = rst_n_in && issue_valid_in &&
                (pending_q[issue_ra_in] || pending_q[issue_rb_in] ||
                 pending_q[issue_rd_in] || fifo_hit);
  end

  always_comb begin
    we_d      = mem_win || fifo_pop;
    rd_d      = '0;
    wd_d      = '0;
    pending_d = pending_q;
    if (mem_win) begin
      rd_d               = mem_rd_in;
      wd_d               = mem_data_in;
      pending_d[mem_rd_in] = 1'b0;
    end else if (fifo_pop) begin
      rd_d = fifo_head.rd;
      wd_d = fifo_head.data;
    end
    // Set after clear: a new load to the same register keeps it pending.
    if (rst_n_in && issue_valid_in && issue_is_load_in && !stall_out && (issue_rd_in != '0))
      pending_d[issue_rd_in] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      we_q      <= 1'b0;
      rd_q      <= '0;
      wd_q      <= '0;
      pending_q <= '0;
    end else begin
      we_q      <= we_d;
      rd_q      <= rd_d;
      wd_q      <= wd_d;
      pending_q <= pending_d;
    end
  end

  assign write_enable_out = we_q;
  assign rd_out           = rd_q;
  assign wd_out           = wd_q;

`ifdef WB_ARB_PERF_EN
  xlen_t stall_cnt_q, stall_cnt_d;
  xlen_t conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    if (stall_out)
      stall_cnt_d = sat_inc(stall_cnt_q);
    if (mem_win && !fifo_empty)
      conflict_cnt_d = sat_inc(conflict_cnt_q);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      stall_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign stall_cycles_out    = stall_cnt_q;
  assign conflict_cycles_out = conflict_cnt_q;
`else
  assign stall_cycles_out    = '0;
  assign conflict_cycles_out = '0;
`endif

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed bench for riscv_wb_arbiter: ALU-only path, load/ALU conflict,
// backpressure, load hazards, x0 handling and mid-flight reset.
module tb_riscv_wb_arbiter;

`ifdef WB_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        alu_valid_in;
  logic [4:0]  alu_rd_in;
  logic [31:0] alu_data_in;
  logic        alu_ready_out;
  logic        mem_valid_in;
  logic [4:0]  mem_rd_in;
  logic [31:0] mem_data_in;
  logic        issue_valid_in;
  logic        issue_is_load_in;
  logic [4:0]  issue_ra_in;
  logic [4:0]  issue_rb_in;
  logic [4:0]  issue_rd_in;
  logic        stall_out;
  logic        write_enable_out;
  logic [4:0]  rd_out;
  logic [31:0] wd_out;
  logic [31:0] stall_cycles_out;
  logic [31:0] conflict_cycles_out;

  int total = 0;
  int bad   = 0;

  riscv_wb_arbiter #(.ALU_FIFO_DEPTH(2)) dut (
    .clk_in              (clk_in),
    .rst_n_in            (rst_n_in),
    .alu_valid_in        (alu_valid_in),
    .alu_rd_in           (alu_rd_in),
    .alu_data_in         (alu_data_in),
    .alu_ready_out       (alu_ready_out),
    .mem_valid_in        (mem_valid_in),
    .mem_rd_in           (mem_rd_in),
    .mem_data_in         (mem_data_in),
    .issue_valid_in      (issue_valid_in),
    .issue_is_load_in    (issue_is_load_in),
    .issue_ra_in         (issue_ra_in),
    .issue_rb_in         (issue_rb_in),
    .issue_rd_in         (issue_rd_in),
    .stall_out           (stall_out),
    .write_enable_out    (write_enable_out),
    .rd_out              (rd_out),
    .wd_out              (wd_out),
    .stall_cycles_out    (stall_cycles_out),
    .conflict_cycles_out (conflict_cycles_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] wd);
    chk({tag, ".we"}, 32'(write_enable_out), 32'(we));
    if (we) begin
      chk({tag, ".rd"}, 32'(rd_out), 32'(rd));
      chk({tag, ".wd"}, wd_out, wd);
    end
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid_in = v; alu_rd_in = rd; alu_data_in = d;
  endtask

  task automatic set_mem(input logic v, input logic [4:0] rd, input logic [31:0] d);
    mem_valid_in = v; mem_rd_in = rd; mem_data_in = d;
  endtask

  task automatic set_issue(input logic v, input logic ld, input logic [4:0] ra,
                           input logic [4:0] rb, input logic [4:0] rd);
    issue_valid_in = v; issue_is_load_in = ld;
    issue_ra_in = ra; issue_rb_in = rb; issue_rd_in = rd;
  endtask

  initial begin
    rst_n_in = 1'b0;
    set_alu(1'b1, 5'd1, 32'h1);
    set_mem(1'b1, 5'd2, 32'h2);
    set_issue(1'b1, 1'b1, 5'd3, 5'd0, 5'd3);

    // Reset with all sources asserted: nothing may take effect.
    #1;
    chk("rst.ready", 32'(alu_ready_out), 32'd0);
    chk("rst.stall", 32'(stall_out), 32'd0);
    tick(); tick();
    chk_wr("rst.wr", 1'b0, 5'd0, 32'd0);
    chk("rst.rd", 32'(rd_out), 32'd0);
    chk("rst.wd", wd_out, 32'd0);
    chk("rst.stallcnt", stall_cycles_out, 32'd0);
    chk("rst.conflcnt", conflict_cycles_out, 32'd0);

    set_alu(1'b0, 5'd0, 32'd0);
    set_mem(1'b0, 5'd0, 32'd0);
    set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    rst_n_in = 1'b1;
    tick();
    chk("post_rst.ready", 32'(alu_ready_out), 32'd1);
    chk_wr("post_rst.wr", 1'b0, 5'd0, 32'd0);

    // ALU-only: write appears two cycles after acceptance, for one cycle.
    set_alu(1'b1, 5'd5, 32'h1234);
    #1;
    chk("alu.ready", 32'(alu_ready_out), 32'd1);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    chk_wr("alu.c1", 1'b0, 5'd0, 32'd0);
    tick();
    chk_wr("alu.c2", 1'b1, 5'd5, 32'h1234);
    tick();
    chk_wr("alu.c3", 1'b0, 5'd0, 32'd0);

    // Conflict: buffered rd=3 versus load rd=7 in the same cycle.
    set_alu(1'b1, 5'd3, 32'h33);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    set_mem(1'b1, 5'd7, 32'hAA);
    tick();
    set_mem(1'b0, 5'd0, 32'd0);
    chk_wr("confl.mem", 1'b1, 5'd7, 32'hAA);
    tick();
    chk_wr("confl.alu", 1'b1, 5'd3, 32'h33);
    chk("confl.cnt", conflict_cycles_out, PERF ? 32'd1 : 32'd0);
    tick();
    chk_wr("confl.idle", 1'b0, 5'd0, 32'd0);

    // Backpressure: loads every cycle fill the two-entry buffer.
    set_mem(1'b1, 5'd10, 32'hA0);
    set_alu(1'b1, 5'd11, 32'hB1);
    #1;
    chk("bp.ready0", 32'(alu_ready_out), 32'd1);
    tick();
    chk_wr("bp.w0", 1'b1, 5'd10, 32'hA0);
    set_alu(1'b1, 5'd12, 32'hB2);
    #1;
    chk("bp.ready1", 32'(alu_ready_out), 32'd1);
    tick();
    chk_wr("bp.w1", 1'b1, 5'd10, 32'hA0);
    set_alu(1'b1, 5'd13, 32'hB3);
    #1;
    chk("bp.ready2", 32'(alu_ready_out), 32'd0);
    tick();
    chk("bp.ready3", 32'(alu_ready_out), 32'd0);
    tick();
    set_mem(1'b0, 5'd0, 32'd0);
    #1;
    chk("bp.ready_drain", 32'(alu_ready_out), 32'd1);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    chk_wr("bp.o11", 1'b1, 5'd11, 32'hB1);
    tick();
    chk_wr("bp.o12", 1'b1, 5'd12, 32'hB2);
    tick();
    chk_wr("bp.o13", 1'b1, 5'd13, 32'hB3);
    tick();
    chk_wr("bp.idle", 1'b0, 5'd0, 32'd0);
    chk("bp.conflcnt", conflict_cycles_out, PERF ? 32'd4 : 32'd0);

    // Load hazard on rd=4.
    set_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd4);
    #1;
    chk("lh.issue_load", 32'(stall_out), 32'd0);
    tick();
    set_issue(1'b1, 1'b0, 5'd4, 5'd0, 5'd1);
    #1;
    chk("lh.stall1", 32'(stall_out), 32'd1);
    tick();
    chk("lh.stall2", 32'(stall_out), 32'd1);
    tick();
    set_mem(1'b1, 5'd4, 32'h44);
    #1;
    chk("lh.stall_commit", 32'(stall_out), 32'd1);
    tick();
    set_mem(1'b0, 5'd0, 32'd0);
    chk_wr("lh.wr4", 1'b1, 5'd4, 32'h44);
    chk("lh.cleared", 32'(stall_out), 32'd0);
    // New load to rd=4 in the same cycle a load to rd=4 commits.
    set_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd4);
    set_mem(1'b1, 5'd4, 32'h55);
    #1;
    chk("lh.setclr_nostall", 32'(stall_out), 32'd0);
    tick();
    set_mem(1'b0, 5'd0, 32'd0);
    set_issue(1'b1, 1'b0, 5'd4, 5'd0, 5'd1);
    #1;
    chk("lh.set_wins", 32'(stall_out), 32'd1);
    tick();
    set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    set_mem(1'b1, 5'd4, 32'h66);
    tick();
    set_mem(1'b0, 5'd0, 32'd0);
    set_issue(1'b1, 1'b0, 5'd4, 5'd0, 5'd1);
    #1;
    chk("lh.final_clear", 32'(stall_out), 32'd0);
    chk("lh.stallcnt", stall_cycles_out, PERF ? 32'd4 : 32'd0);
    set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

    // Hazard against a buffered ALU result (rb matches).
    set_alu(1'b1, 5'd6, 32'h60);
    set_mem(1'b1, 5'd8, 32'h80);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    set_issue(1'b1, 1'b0, 5'd0, 5'd6, 5'd1);
    #1;
    chk("fh.stall", 32'(stall_out), 32'd1);
    tick();
    set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    set_mem(1'b0, 5'd0, 32'd0);
    tick();
    chk_wr("fh.wr6", 1'b1, 5'd6, 32'h60);
    chk("fh.stallcnt", stall_cycles_out, PERF ? 32'd5 : 32'd0);
    chk("fh.conflcnt", conflict_cycles_out, PERF ? 32'd5 : 32'd0);
    tick();

    // x0 writes from either source are dropped; load to x0 sets nothing.
    set_alu(1'b1, 5'd0, 32'hDEAD);
    set_mem(1'b1, 5'd0, 32'hBEEF);
    set_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    chk("x0.ready", 32'(alu_ready_out), 32'd1);
    chk("x0.stall", 32'(stall_out), 32'd0);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    set_mem(1'b0, 5'd0, 32'd0);
    set_issue(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    chk_wr("x0.c1", 1'b0, 5'd0, 32'd0);
    chk("x0.stall_after", 32'(stall_out), 32'd0);
    tick();
    chk_wr("x0.c2", 1'b0, 5'd0, 32'd0);
    set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

    // Reset with two buffered results and rd=9 pending.
    set_mem(1'b1, 5'd2, 32'h22);
    set_alu(1'b1, 5'd20, 32'h200);
    set_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd9);
    tick();
    set_alu(1'b1, 5'd21, 32'h210);
    set_issue(1'b1, 1'b0, 5'd9, 5'd0, 5'd1);
    #1;
    chk("mr.pending9", 32'(stall_out), 32'd1);
    tick();
    chk("mr.full", 32'(alu_ready_out), 32'd0);
    rst_n_in = 1'b0;
    set_alu(1'b0, 5'd0, 32'd0);
    #1;
    chk("mr.rst_ready", 32'(alu_ready_out), 32'd0);
    chk("mr.rst_stall", 32'(stall_out), 32'd0);
    tick();
    chk_wr("mr.rst_wr", 1'b0, 5'd0, 32'd0);
    chk("mr.rst_rd", 32'(rd_out), 32'd0);
    chk("mr.rst_wd", wd_out, 32'd0);
    chk("mr.rst_conflcnt", conflict_cycles_out, 32'd0);
    rst_n_in = 1'b1;
    set_mem(1'b0, 5'd0, 32'd0);
    #1;
    chk("mr.ready", 32'(alu_ready_out), 32'd1);
    chk("mr.stall9", 32'(stall_out), 32'd0);
    tick();
    chk_wr("mr.nowr1", 1'b0, 5'd0, 32'd0);
    tick();
    chk_wr("mr.nowr2", 1'b0, 5'd0, 32'd0);
    chk("mr.stallcnt", stall_cycles_out, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
